// File: rtl/ft245_sff_bridge_pkg.sv
// Shared types and constants for the FT245 synchronous-FIFO bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bridge FSM state enum, burst-counter width, default sizing.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_OE  = 3'd1,
    ST_RD     = 3'd2,
    ST_RD_END = 3'd3,
    ST_WR     = 3'd4,
    ST_WR_END = 3'd5
  } state_t;

  // Burst counters are 7 bits so a burst limit of up to 127 bytes fits.
  localparam int BURST_CNT_W      = 7;
  localparam int DEF_TX_DEPTH     = 16;
  localparam int DEF_RD_BURST_MAX = 64;
  localparam int DEF_WR_BURST_MAX = 64;

endpackage

// File: rtl/ft245_sff_bridge_if.sv
// Pin and core-stream bundle of the FT245 bridge.
// Latency: n/a (wiring only).
// Backpressure: ingress has none; egress reports EFull and sticky EOvf.
// Ports: FT245 pins (RXFn, TXEn, RDn, WRn, OEn, DIn, DOut, DOutEn),
//        ingress stream (IValid, ID), egress stream (EValid, ED, EFull, EOvf).
// Build option FT245_COUNTERS_EN adds RxCount/TxCount transfer counters.
interface ft245_sff_bridge_if;
  logic       RXFn;
  logic       TXEn;
  logic       RDn;
  logic       WRn;
  logic       OEn;
  logic [7:0] DIn;
  logic [7:0] DOut;
  logic       DOutEn;
  logic       IValid;
  logic [7:0] ID;
  logic       EValid;
  logic [7:0] ED;
  logic       EFull;
  logic       EOvf;
`ifdef FT245_COUNTERS_EN
  logic [15:0] RxCount;
  logic [15:0] TxCount;
`endif

  // master = the bridge, slave = pads + core around it.
  modport master (
    input  RXFn, TXEn, DIn, EValid, ED,
    output RDn, WRn, OEn, DOut, DOutEn, IValid, ID, EFull, EOvf
`ifdef FT245_COUNTERS_EN
    , output RxCount, TxCount
`endif
  );

  modport slave (
    output RXFn, TXEn, DIn, EValid, ED,
    input  RDn, WRn, OEn, DOut, DOutEn, IValid, ID, EFull, EOvf
`ifdef FT245_COUNTERS_EN
    , input RxCount, TxCount
`endif
  );
endinterface

// File: rtl/ft245_sff_bridge_sync_byte_fifo.sv
// Show-ahead byte FIFO used as the bridge egress buffer.
// Latency: a pushed byte is visible on o_dout the cycle after the push.
// Backpressure: o_full; push while full is ignored unless a pop frees a slot.
// Ports: Clk/ARst, i_push/i_din, i_pop, o_dout (head), o_full, o_empty, o_count.
module sync_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          Clk,
  input  logic          ARst,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_dout   = r_mem[r_rd_ptr];

  // A pop at full frees the slot the concurrent push lands in.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ft245_sff_bridge.sv
// FT245 synchronous-FIFO bridge: host bytes -> ingress stream, egress FIFO -> host.
// Latency: ingress byte on IValid/ID one cycle after its read edge; egress byte
//          drives DOut from the FIFO head (show-ahead).
// Backpressure: ingress none; egress EFull, bytes pushed while full dropped + EOvf.
// Ports: Clk, ARst (async, active-high), bus (ft245_sff_bridge_if.master).
// Build option FT245_COUNTERS_EN adds RxCount/TxCount (16-bit, wrapping).
module ft245_sff_bridge
  import ft245_pkg::*;
#(
  parameter int TX_DEPTH     = DEF_TX_DEPTH,
  parameter int RD_BURST_MAX = DEF_RD_BURST_MAX,
  parameter int WR_BURST_MAX = DEF_WR_BURST_MAX
) (
  input  logic               Clk,
  input  logic               ARst,
  ft245_sff_bridge_if.master bus
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [BURST_CNT_W-1:0] RD_MAX_C = BURST_CNT_W'(RD_BURST_MAX);
  localparam logic [BURST_CNT_W-1:0] WR_MAX_C = BURST_CNT_W'(WR_BURST_MAX);

  state_t                 r_state;
  logic                   r_rdn;
  logic                   r_wrn;
  logic                   r_oen;
  logic                   r_douten;
  logic                   r_last_rd;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic                   r_ivalid;
  logic [7:0]             r_id;
  logic                   r_eovf;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_cnt;
  logic [7:0]             w_fifo_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_rd_xfer;
  logic                   w_wr_xfer;
  logic                   w_rx_pend;
  logic                   w_tx_pend;
  logic                   w_fifo_drains;
  logic [BURST_CNT_W-1:0] w_cnt_sat_rd;
  logic [BURST_CNT_W-1:0] w_cnt_sat_wr;

  assign w_rx_pend = !bus.RXFn;
  assign w_tx_pend = !bus.TXEn && !w_fifo_empty;

  // Strobes are low only inside their burst state, so the strobe alone
  // qualifies a transfer edge.
  assign w_rd_xfer = !r_rdn && !bus.RXFn;
  assign w_wr_xfer = !r_wrn && !bus.TXEn;

  assign w_push = bus.EValid && !w_fifo_full;
  assign w_pop  = w_wr_xfer;

  // Last byte leaves on this edge and nothing refills it.
  assign w_fifo_drains = w_pop && !w_push && (w_fifo_cnt == CW'(1));

  assign w_cnt_sat_rd = (r_burst_cnt >= RD_MAX_C) ? RD_MAX_C : r_burst_cnt + BURST_CNT_W'(1);
  assign w_cnt_sat_wr = (r_burst_cnt >= WR_MAX_C) ? WR_MAX_C : r_burst_cnt + BURST_CNT_W'(1);

  sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .Clk     (Clk),
    .ARst    (ARst),
    .i_push  (w_push),
    .i_din   (bus.ED),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Bus FSM. Strobe registers are loaded with the values of the state being
  // entered, so every pin output is a flop.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      r_state     <= ST_IDLE;
      r_rdn       <= 1'b1;
      r_wrn       <= 1'b1;
      r_oen       <= 1'b1;
      r_douten    <= 1'b0;
      r_last_rd   <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // RX wins a tie unless the previous burst was already a read.
          if (w_rx_pend && (!w_tx_pend || !r_last_rd)) begin
            r_state     <= ST_RD_OE;
            r_oen       <= 1'b0;
            r_burst_cnt <= '0;
          end else if (w_tx_pend) begin
            r_state     <= ST_WR;
            r_wrn       <= 1'b0;
            r_douten    <= 1'b1;
            r_burst_cnt <= '0;
          end
        end
        ST_RD_OE: begin
          r_state <= ST_RD;
          r_rdn   <= 1'b0;
        end
        ST_RD: begin
          if (w_rd_xfer) r_burst_cnt <= w_cnt_sat_rd;
          if (bus.RXFn || (w_cnt_sat_rd == RD_MAX_C)) begin
            r_state <= ST_RD_END;
            r_rdn   <= 1'b1;
            r_oen   <= 1'b1;
          end
        end
        ST_RD_END: begin
          r_state   <= ST_IDLE;
          r_last_rd <= 1'b1;
        end
        ST_WR: begin
          if (w_wr_xfer) r_burst_cnt <= w_cnt_sat_wr;
          if (bus.TXEn || w_fifo_drains || (w_cnt_sat_wr == WR_MAX_C)) begin
            r_state  <= ST_WR_END;
            r_wrn    <= 1'b1;
            r_douten <= 1'b0;
          end
        end
        ST_WR_END: begin
          r_state   <= ST_IDLE;
          r_last_rd <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_rdn    <= 1'b1;
          r_wrn    <= 1'b1;
          r_oen    <= 1'b1;
          r_douten <= 1'b0;
        end
      endcase
    end
  end

  // Ingress capture and sticky overflow flag.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      r_ivalid <= 1'b0;
      r_id     <= '0;
      r_eovf   <= 1'b0;
    end else begin
      r_ivalid <= w_rd_xfer;
      if (w_rd_xfer) r_id <= bus.DIn;
      if (bus.EValid && w_fifo_full) r_eovf <= 1'b1;
    end
  end

`ifdef FT245_COUNTERS_EN
  logic [15:0] r_rx_count;
  logic [15:0] r_tx_count;

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      r_rx_count <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_rd_xfer) r_rx_count <= r_rx_count + 16'd1;
      if (w_wr_xfer) r_tx_count <= r_tx_count + 16'd1;
    end
  end

  assign bus.RxCount = r_rx_count;
  assign bus.TxCount = r_tx_count;
`endif

  assign bus.RDn    = r_rdn;
  assign bus.WRn    = r_wrn;
  assign bus.OEn    = r_oen;
  assign bus.DOutEn = r_douten;
  assign bus.DOut   = w_fifo_head;
  assign bus.IValid = r_ivalid;
  assign bus.ID     = r_id;
  assign bus.EFull  = w_fifo_full;
  assign bus.EOvf   = r_eovf;

endmodule

// File: tb/tb_ft245_sff_bridge.sv
// Testbench for ft245_sff_bridge: FT245 host model + core model, queue scoreboards.
// Inputs driven on the falling edge; ingress sampled 1 unit after the rising edge,
// host-side write capture sampled 1 unit after the falling edge.
module tb_ft245_sff_bridge;
  import ft245_pkg::*;

  localparam int DEPTH = 16;
  localparam int RDMAX = 4;
  localparam int WRMAX = 8;

  logic Clk  = 1'b0;
  logic ARst = 1'b0;
  always #5 Clk = ~Clk;

  ft245_sff_bridge_if bus();

  ft245_sff_bridge #(.TX_DEPTH(DEPTH), .RD_BURST_MAX(RDMAX), .WR_BURST_MAX(WRMAX)) dut (
    .Clk  (Clk),
    .ARst (ARst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] host_q[$];  // bytes the host still has to hand over
  logic [7:0] exp_ing[$]; // expected ingress bytes, in order
  logic [7:0] exp_egr[$]; // expected bytes the host will receive, in order
  logic [7:0] log_q[$];   // transfer kinds ("R"/"W") in order
  int  occ = 0;           // bytes accepted by the egress buffer, not yet written out
  bit  exp_ovf = 0;
  bit  rd_flag = 0, wr_flag = 0, push_flag = 0; // transfers due at the coming rising edge
  bit  rx_block = 0, tx_block = 0, log_en = 0;
  int  rx_total = 0, tx_total = 0, wr_seen = 0, ivalid_cnt = 0;
  logic prev_rdn = 1'b1, prev_oen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] b);
    host_q.push_back(b);
    exp_ing.push_back(b);
  endtask

  // One clock: account for the edge just gone, check flags, drive next inputs.
  task automatic step(input bit ev, input logic [7:0] ed);
    @(negedge Clk);
    if (rd_flag) begin host_q.delete(0); rx_total++; end
    if (wr_flag) begin occ--; tx_total++; wr_seen++; end
    if (push_flag) occ++;
    if (!ARst) begin
      chk("efull", bus.EFull, 32'(occ == DEPTH));
      chk("eovf", bus.EOvf, 32'(exp_ovf));
    end
    bus.RXFn   = (host_q.size() == 0) || rx_block;
    bus.DIn    = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
    bus.TXEn   = tx_block;
    bus.EValid = ev;
    bus.ED     = ed;
    push_flag  = 0;
    if (ev && !ARst) begin
      if (occ < DEPTH) begin push_flag = 1; exp_egr.push_back(ed); end
      else exp_ovf = 1;
    end
    rd_flag = !bus.RDn && !bus.RXFn && !ARst;
    wr_flag = !bus.WRn && !bus.TXEn && !ARst;
    if (log_en) begin
      if (rd_flag) log_q.push_back("R");
      if (wr_flag) log_q.push_back("W");
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    bit done;
    rx_block = 0;
    tx_block = 0;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      step(0, 8'h00);
      n++;
      done = (host_q.size() == 0) && (exp_ing.size() == 0) && (occ == 0) &&
             (exp_egr.size() == 0) && bus.RDn && bus.WRn && bus.OEn;
    end
    chk({name, "_drained"}, 32'(done), 1);
    step(0, 8'h00);
    step(0, 8'h00);
  endtask

  // Ingress monitor.
  always @(posedge Clk) begin
    #1;
    if (!ARst) begin
      chk("ivalid_latency", bus.IValid, 32'(rd_flag));
      if (bus.IValid) begin
        ivalid_cnt++;
        if (exp_ing.size() == 0) begin
          checks++; errors++;
          $display("FAIL ingress_extra: got %0h want none", bus.ID);
        end else chk("ingress_byte", bus.ID, exp_ing.pop_front());
      end
      chk("oe_douten_excl", 32'(!bus.OEn && bus.DOutEn), 0);
      if (prev_rdn && !bus.RDn) chk("oe_before_rd", prev_oen, 0);
    end
    prev_rdn = bus.RDn;
    prev_oen = bus.OEn;
  end

  // Host-side write monitor: the byte latched by the host at the coming edge.
  always @(negedge Clk) begin
    #1;
    if (!ARst && !bus.WRn && !bus.TXEn) begin
      chk("douten_in_wr", bus.DOutEn, 1);
      if (exp_egr.size() == 0) begin
        checks++; errors++;
        $display("FAIL egress_extra: got %0h want none", bus.DOut);
      end else chk("egress_byte", bus.DOut, exp_egr.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bus.RXFn = 1'b1; bus.TXEn = 1'b1; bus.DIn = '0; bus.EValid = 1'b0; bus.ED = '0;
    #1 ARst = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_rdn", bus.RDn, 1);
    chk("rst_wrn", bus.WRn, 1);
    chk("rst_oen", bus.OEn, 1);
    chk("rst_douten", bus.DOutEn, 0);
    chk("rst_ivalid", bus.IValid, 0);
    chk("rst_id", bus.ID, 0);
    chk("rst_dout", bus.DOut, 0);
    chk("rst_efull", bus.EFull, 0);
    chk("rst_eovf", bus.EOvf, 0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(negedge Clk) ARst = 1'b0;

    // RX only
    base = ivalid_cnt;
    host_push(8'h11); host_push(8'h22); host_push(8'h33);
    n = 0;
    while (host_q.size() != 0 && n < 50) begin step(0, 8'h00); n++; end
    chk("rx_only_consumed", 32'(host_q.size()), 0);
    step(0, 8'h00); step(0, 8'h00);
    chk("rx_only_rdn_high", bus.RDn, 1);
    chk("rx_only_oen_high", bus.OEn, 1);
    chk("rx_only_pulses", 32'(ivalid_cnt - base), 3);
    drain(50, "rx_only");

    // TX only
    base = wr_seen;
    for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i));
    drain(100, "tx_only");
    chk("tx_only_count", 32'(wr_seen - base), 5);
    chk("tx_only_wrn_high", bus.WRn, 1);

    // TX throttle after the 2nd byte
    tx_block = 1;
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i));
    tx_block = 0;
    base = wr_seen;
    n = 0;
    while ((wr_seen - base + int'(wr_flag)) < 2 && n < 100) begin step(0, 8'h00); n++; end
    tx_block = 1;
    step(0, 8'h00); step(0, 8'h00);
    tx_block = 0;
    drain(100, "tx_throttle");
    chk("tx_throttle_count", 32'(wr_seen - base), 4);

    // Overflow: 17 bytes into a 16-deep buffer with the host not accepting
    tx_block = 1;
    base = wr_seen;
    for (int i = 0; i < 17; i++) step(1, 8'hC0 + 8'(i));
    step(0, 8'h00);
    chk("ovf_efull", bus.EFull, 1);
    chk("ovf_eovf", bus.EOvf, 1);
    drain(200, "overflow");
    chk("ovf_written", 32'(wr_seen - base), 16);

    // Reset in the middle of a read burst
    for (int i = 0; i < 8; i++) host_push(8'h50 + 8'(i));
    n = 0;
    while (bus.RDn && n < 50) begin step(0, 8'h00); n++; end
    chk("mid_rd_reached", bus.RDn, 0);
    ARst = 1'b1;
    rd_flag = 0; wr_flag = 0; push_flag = 0;
    host_q.delete(); exp_ing.delete(); exp_egr.delete();
    occ = 0; exp_ovf = 0; rx_total = 0; tx_total = 0;
    #1;
    chk("arst_rdn", bus.RDn, 1);
    chk("arst_oen", bus.OEn, 1);
    chk("arst_wrn", bus.WRn, 1);
    chk("arst_ivalid", bus.IValid, 0);
    chk("arst_douten", bus.DOutEn, 0);
    step(0, 8'h00); step(0, 8'h00);
    ARst = 1'b0;
    step(0, 8'h00); step(0, 8'h00);
    chk("post_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("post_rst_empty", 32'(dut.w_fifo_empty), 1);
    chk("post_rst_eovf", bus.EOvf, 0);

    // Arbitration: reads and a pending write burst compete
    tx_block = 1;
    for (int i = 0; i < 4; i++) step(1, 8'hE0 + 8'(i));
    log_q.delete();
    log_en = 1;
    for (int i = 0; i < 12; i++) host_push(8'h60 + 8'(i));
    tx_block = 0;
    drain(200, "arbitration");
    log_en = 0;
    chk("arb_len", 32'(log_q.size()), 16);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i < 4 || i >= 8) ? 8'("R") : 8'("W");
      if (i < log_q.size()) chk("arb_order", log_q[i], e);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2) == 0 && host_q.size() < 6) host_push(8'($urandom));
      rx_block = ($urandom_range(4) == 0);
      tx_block = ($urandom_range(3) == 0);
      step($urandom_range(2) == 0, 8'($urandom));
    end
    drain(600, "random");

`ifdef FT245_COUNTERS_EN
    chk("rx_count", bus.RxCount, 32'(rx_total[15:0]));
    chk("tx_count", bus.TxCount, 32'(tx_total[15:0]));
`endif
    chk("end_ing_empty", 32'(exp_ing.size()), 0);
    chk("end_egr_empty", 32'(exp_egr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
